// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : forwarding selects, load-use/redirect stalls and MDU hold
//                    control for the D/E pipeline register and its neighbours.
// Optional feature : PIPE_HAZARD_STATS_EN enables the stall_cnt statistics.
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MDU_MAX_CYC = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        e_redirect,
  input  logic        e_mdu,
  input  logic        mdu_done,
  output logic [1:0]  da_depen,
  output logic [1:0]  db_depen,
  output logic        wpcir,
  output logic        dflush,
  output logic        dbubble,
  output logic        ehold,
  output logic        mdu_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [7:0] MAX_CNT = MDU_MAX_CYC[7:0];

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       timeout_q, timeout_d;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] e_rn, input logic e_wr, input logic e_ld,
    input logic [4:0] m_rn, input logic m_wr, input logic m_ld
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      // A matching E-stage load falls through to 00; the load-use stall covers it.
      if (e_wr && (e_rn == src)) begin
        sel = e_ld ? 2'b00 : 2'b01;
      end else if (m_wr && (m_rn == src)) begin
        sel = m_ld ? 2'b11 : 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    da_depen = 2'b00;
    db_depen = 2'b00;
    if (!clr) begin
      da_depen = fwd_sel(drs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
      db_depen = fwd_sel(drt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
    end
  end

  assign load_use = ewreg && em2reg && (ern != 5'd0) &&
                    ((d_use_rs && (ern == drs)) || (d_use_rt && (ern == drt)));

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    wpcir     = 1'b1;
    dflush    = 1'b0;
    dbubble   = 1'b0;
    ehold     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (e_mdu && !mdu_done) begin
          ehold   = 1'b1;
          wpcir   = 1'b0;
          state_d = ST_MDU_WAIT;
          cnt_d   = 8'd1;
        end else if (e_redirect) begin
          dflush  = 1'b1;
          dbubble = 1'b1;
        end else if (load_use) begin
          wpcir   = 1'b0;
          dbubble = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        // Completion releases the hold in the same cycle and preempts any hazard.
        if (mdu_done) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          ehold = 1'b1;
          wpcir = 1'b0;
          cnt_d = cnt_inc;
          if (cnt_inc == MAX_CNT) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      ST_ERR: begin
        ehold     = 1'b1;
        wpcir     = 1'b0;
        timeout_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 8'd0;
      end
    endcase
    if (clr) begin
      wpcir   = 1'b1;
      dflush  = 1'b0;
      dbubble = 1'b0;
      ehold   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_RUN;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mdu_timeout = timeout_q;

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!wpcir && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It sequences the D/E pipeline register and its neighbours. Each cycle it decides, from decode-stage source registers and the destinations in flight in E and M:
- the forwarding selects for the two decode operands (da_depen/db_depen);
- whether the front end stalls;
- whether a bubble or flush is injected;
- whether the pipeline holds for a multi-cycle unit in E.

It sits beside the decode stage and drives the enables of the PC, IF/ID, D/E and E/M registers.

## Interface
- MDU_MAX_CYC, 64: maximum cycles a multi-cycle op may hold E before timeout; legal range 2..255.
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- drs, drt  in  5  decode-stage source register numbers.
- d_use_rs, d_use_rt  in  1  decode instruction actually reads rs / rt.
- ern  in  5  E-stage destination; ewreg, em2reg  in  1  E writes reg / E is a load.
- mrn  in  5  M-stage destination; mwreg, mm2reg  in  1  M writes reg / M is a load.
- e_redirect  in  1  jump or taken branch resolved in E this cycle.
- e_mdu  in  1  E holds a multi-cycle op; mdu_done  in  1  that op's result is valid this cycle.
- da_depen, db_depen  out  2  operand source: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M memory data.
- wpcir  out  1  PC and IF/ID write enable.
- dflush  out  1  IF/ID loads a nop.
- dbubble  out  1  D/E loads all-zero control bits.
- ehold  out  1  D/E holds its value; E/M loads a bubble.
- mdu_timeout  out  1  sticky error flag.
- stall_cnt  out  32  stall statistics (see Configuration).

## Operation
- Forwarding is combinational, evaluated for rs and rt independently. Register 0 never matches.
  - If ewreg, ern==src and !em2reg: select 01.
  - Else if mwreg and mrn==src: select 11 when mm2reg, otherwise 10.
  - Else: select 00.
  - A matching E-stage load yields 00 (don't care, because the load-use stall covers it).
- Load-use: ewreg & em2reg & ern!=0, and (d_use_rs & ern==drs or d_use_rt & ern==drt).
- FSM states: RUN, MDU_WAIT, ERR. A cycle counter (8 bits) is used in MDU_WAIT.
- RUN priority, highest first:
  1. e_mdu & !mdu_done: ehold=1, wpcir=0. Next state MDU_WAIT, counter=1.
  2. e_redirect: dflush=1, dbubble=1, wpcir=1. Any load-use hazard is ignored.
  3. load-use: wpcir=0, dbubble=1.
  4. Otherwise: wpcir=1, all other controls 0.
  - e_mdu & mdu_done in the same cycle causes no stall.
- MDU_WAIT:
  - Outputs: ehold=1, wpcir=0, dflush=0, dbubble=0. Counter increments.
  - mdu_done: in that same cycle ehold=0 and wpcir=1, next state RUN. Load-use and redirect are not evaluated in that cycle.
  - Counter reaches MDU_MAX_CYC without mdu_done: next state ERR.
- ERR: ehold=1, wpcir=0, mdu_timeout=1. Exit only via clr.
- Reset (clr=1 at an edge): state RUN, counter 0, mdu_timeout 0, stall_cnt 0. Reset mid-MDU_WAIT abandons the wait.
- Outputs while clr is high: wpcir=1, dflush=0, dbubble=0, ehold=0, depen=00.

## Timing
- All control and forwarding outputs are combinational from the inputs and the current state, valid in the same cycle. Zero-cycle latency.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in M and the select is 11.
- A redirect costs 2 squashed slots (IF and D), both flushed in the same cycle.
- MDU hold of N cycles: wpcir is low for N cycles, and ehold is high from the first cycle through the cycle before mdu_done.
- The state register, counter, mdu_timeout and stall_cnt update on the rising edge of clk.

## Configuration
- PIPE_HAZARD_STATS_EN defined: stall_cnt increments on every non-reset cycle with wpcir=0. It saturates at 32'hFFFFFFFF and clears on clr.
- PIPE_HAZARD_STATS_EN undefined: stall_cnt is tied to 0 and no counter logic is synthesised. The port is kept so benches are unchanged.

## Test plan
- E: ewreg=1, em2reg=0, ern=5; D: drs=5, d_use_rs=1 -> da_depen=01, wpcir=1, no bubble.
- E load to r8, D reads rt=8 -> cycle 0: wpcir=0, dbubble=1. Next cycle (load in M, mm2reg=1, mrn=8): db_depen=11, wpcir=1.
- e_redirect=1 together with a load-use hazard -> dflush=1, dbubble=1, wpcir=1. stall_cnt is unchanged with PIPE_HAZARD_STATS_EN.
- e_mdu=1, mdu_done asserted on the 4th cycle -> ehold=1 for 3 cycles then 0. wpcir low for 3 cycles. State back to RUN. stall_cnt +3.
- MDU_MAX_CYC=8, mdu_done never asserted -> ERR after 8 cycles, mdu_timeout=1 and stays; clr=1 for 1 cycle -> RUN, mdu_timeout=0.
- drs=0, ewreg=1, ern=0 -> da_depen=00, no stall.
